// File: rtl/elevator_ctrl.sv
// Single-car collective-SCAN elevator controller. It latches up to seven passenger requests
// and serves them over floors 0..7, reporting door, motion and delivery status.
module elevator_ctrl #(
   parameter int MOVE_CYCLES = 4,
   parameter int DOOR_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [5:0] passenger_1,
   input  logic [5:0] passenger_2,
   input  logic [5:0] passenger_3,
   input  logic [5:0] passenger_4,
   input  logic [5:0] passenger_5,
   input  logic [5:0] passenger_6,
   input  logic [5:0] passenger_7,
   input  logic [6:0] up_passenger,
   input  logic [6:0] down_passenger,
   output logic [2:0] floor,
   output logic       dir_up,
   output logic       moving,
   output logic       door_open,
   output logic       busy,
   output logic [6:0] onboard,
   output logic [6:0] served,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   localparam logic [15:0] MOVE_LAST = 16'(MOVE_CYCLES - 1);
   localparam logic [15:0] DOOR_LAST = 16'(DOOR_CYCLES - 1);

   state_t            state, state_n;
   logic [15:0]       cnt, cnt_n;
   logic [2:0]        floor_n;
   logic              dir_n;
   logic [6:0]        onboard_n, served_n;
   logic              done_n;
   logic              latch_en;

   logic [6:0][2:0]   src_q, dst_q;
   logic [6:0]        up_q, valid_q;

   logic [6:0][2:0]   in_src, in_dst;
   logic [6:0]        in_valid;

   logic [6:0][2:0]   eff_src, eff_dst;
   logic [6:0]        eff_up, eff_valid, eff_onboard, eff_served;
   logic [6:0]        waiting;

   logic [2:0]        step_floor, entry_floor;
   logic              entry_dir;
   logic [6:0]        src_here, dst_here, go_same, board, board_drop;
   logic              tgt_ahead, dep_dir, stop_here;
   logic [6:0]        entry_onboard, entry_served;
   logic              idle_above, door_ahead, door_wait_here, any_target;

   function automatic logic [6:0] at_floor(input logic [6:0][2:0] codes,
                                           input logic [6:0] mask,
                                           input logic [2:0] f);
      logic [6:0] r;
      r = '0;
      for (int i = 0; i < 7; i++)
         r[i] = mask[i] && (codes[i] == f);
      return r;
   endfunction

   function automatic logic any_ahead(input logic [6:0][2:0] codes,
                                      input logic [6:0] mask,
                                      input logic [2:0] f,
                                      input logic d);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 7; i++)
         if (mask[i] && (d ? (codes[i] > f) : (codes[i] < f)))
            r = 1'b1;
      return r;
   endfunction

   always_comb begin
      in_src[0] = passenger_1[2:0];  in_dst[0] = passenger_1[5:3];
      in_src[1] = passenger_2[2:0];  in_dst[1] = passenger_2[5:3];
      in_src[2] = passenger_3[2:0];  in_dst[2] = passenger_3[5:3];
      in_src[3] = passenger_4[2:0];  in_dst[3] = passenger_4[5:3];
      in_src[4] = passenger_5[2:0];  in_dst[4] = passenger_5[5:3];
      in_src[5] = passenger_6[2:0];  in_dst[5] = passenger_6[5:3];
      in_src[6] = passenger_7[2:0];  in_dst[6] = passenger_7[5:3];
      in_valid  = up_passenger ^ down_passenger;
   end

   // On the accepting load edge the first decision must see the incoming request set.
   always_comb begin
      if (state == IDLE && load) begin
         eff_src     = in_src;
         eff_dst     = in_dst;
         eff_up      = up_passenger;
         eff_valid   = in_valid;
         eff_onboard = '0;
         eff_served  = '0;
      end else begin
         eff_src     = src_q;
         eff_dst     = dst_q;
         eff_up      = up_q;
         eff_valid   = valid_q;
         eff_onboard = onboard;
         eff_served  = served;
      end
      waiting = eff_valid & ~eff_onboard & ~eff_served;
   end

   always_comb begin
      step_floor = floor;
      if (dir_up && floor != 3'd7)
         step_floor = floor + 3'd1;
      else if (!dir_up && floor != 3'd0)
         step_floor = floor - 3'd1;
   end

   // Door-entry evaluation: arrival floor when moving, opposite direction on a DOOR re-entry.
   always_comb begin
      entry_floor   = (state == MOVE) ? step_floor : floor;
      entry_dir     = (state == DOOR) ? ~dir_up : dir_up;
      src_here      = at_floor(eff_src, waiting, entry_floor);
      dst_here      = at_floor(eff_dst, eff_onboard, entry_floor);
      tgt_ahead     = any_ahead(eff_src, waiting, entry_floor, entry_dir) ||
                      any_ahead(eff_dst, eff_onboard, entry_floor, entry_dir);
      go_same       = src_here & (entry_dir ? eff_up : ~eff_up);
      dep_dir       = (tgt_ahead || (|go_same)) ? entry_dir : ~entry_dir;
      board         = src_here & (dep_dir ? eff_up : ~eff_up);
      board_drop    = board & at_floor(eff_dst, board, entry_floor);
      entry_onboard = ((eff_onboard & ~dst_here) | board) & ~board_drop;
      entry_served  = eff_served | dst_here | board_drop;
      stop_here     = (|dst_here) || (|go_same) || ((|src_here) && !tgt_ahead);
   end

   always_comb begin
      idle_above     = any_ahead(eff_src, waiting, floor, 1'b1);
      door_ahead     = any_ahead(eff_src, waiting, floor, dir_up) ||
                       any_ahead(eff_dst, eff_onboard, floor, dir_up);
      door_wait_here = |at_floor(eff_src, waiting, floor);
      any_target     = (|waiting) || (|eff_onboard);
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      floor_n   = floor;
      dir_n     = dir_up;
      onboard_n = onboard;
      served_n  = served;
      done_n    = 1'b0;
      latch_en  = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               if (|in_valid) begin
                  latch_en  = 1'b1;
                  onboard_n = '0;
                  served_n  = '0;
                  cnt_n     = '0;
                  if (|src_here) begin
                     state_n   = DOOR;
                     dir_n     = dep_dir;
                     onboard_n = entry_onboard;
                     served_n  = entry_served;
                  end else begin
                     state_n = MOVE;
                     dir_n   = idle_above;
                  end
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         MOVE: begin
            if (cnt == MOVE_LAST) begin
               cnt_n   = '0;
               floor_n = step_floor;
               if (stop_here) begin
                  state_n   = DOOR;
                  dir_n     = dep_dir;
                  onboard_n = entry_onboard;
                  served_n  = entry_served;
               end
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         DOOR: begin
            if (cnt == DOOR_LAST) begin
               cnt_n = '0;
               if (door_ahead) begin
                  state_n = MOVE;
               end else if (door_wait_here) begin
                  dir_n     = dep_dir;
                  onboard_n = entry_onboard;
                  served_n  = entry_served;
               end else if (any_target) begin
                  dir_n   = ~dir_up;
                  state_n = MOVE;
               end else begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         floor   <= 3'd0;
         dir_up  <= 1'b1;
         onboard <= '0;
         served  <= '0;
         done    <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         up_q    <= '0;
         valid_q <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         floor   <= floor_n;
         dir_up  <= dir_n;
         onboard <= onboard_n;
         served  <= served_n;
         done    <= done_n;
         if (latch_en) begin
            src_q   <= in_src;
            dst_q   <= in_dst;
            up_q    <= up_passenger;
            valid_q <= in_valid;
         end
      end
   end

   assign moving    = (state == MOVE);
   assign door_open = (state == DOOR);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: reset state, full SCAN run, single trip timing,
// empty/invalid loads, load-while-busy and mid-run reset.
module tb_elevator_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [5:0] passenger_1 = '0, passenger_2 = '0, passenger_3 = '0, passenger_4 = '0;
   logic [5:0] passenger_5 = '0, passenger_6 = '0, passenger_7 = '0;
   logic [6:0] up_passenger = '0, down_passenger = '0;
   logic [2:0] floor;
   logic       dir_up, moving, door_open, busy, done;
   logic [6:0] onboard, served;

   int checks = 0;
   int errors = 0;
   int busy_cycles;
   int stops[$];
   logic [6:0] ob_seen;
   logic       finished;
   logic       end_done;
   logic       hit;

   int exp_t1[9] = '{0, 1, 6, 7, 5, 4, 3, 2, 0};
   int exp_t2[2] = '{0, 3};

   elevator_ctrl #(.MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .load(load),
      .passenger_1(passenger_1), .passenger_2(passenger_2), .passenger_3(passenger_3),
      .passenger_4(passenger_4), .passenger_5(passenger_5), .passenger_6(passenger_6),
      .passenger_7(passenger_7),
      .up_passenger(up_passenger), .down_passenger(down_passenger),
      .floor(floor), .dir_up(dir_up), .moving(moving), .door_open(door_open),
      .busy(busy), .onboard(onboard), .served(served), .done(done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clearInputs();
      load = 1'b0;
      passenger_1 = '0; passenger_2 = '0; passenger_3 = '0; passenger_4 = '0;
      passenger_5 = '0; passenger_6 = '0; passenger_7 = '0;
      up_passenger = '0; down_passenger = '0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Presents a request set for exactly one clock edge; returns at the following negedge.
   task automatic applyStimulus(input logic [5:0] p1, input logic [5:0] p2, input logic [5:0] p3,
                                input logic [5:0] p4, input logic [5:0] p5, input logic [5:0] p6,
                                input logic [5:0] p7, input logic [6:0] up, input logic [6:0] dn);
      @(negedge clk);
      passenger_1 = p1; passenger_2 = p2; passenger_3 = p3; passenger_4 = p4;
      passenger_5 = p5; passenger_6 = p6; passenger_7 = p7;
      up_passenger = up; down_passenger = dn;
      load = 1'b1;
      @(negedge clk);
      clearInputs();
   endtask

   task automatic runToIdle(input int budget, input int inject_at);
      logic prev_door;
      busy_cycles = 0;
      stops.delete();
      ob_seen = '0;
      finished = 1'b0;
      end_done = 1'b0;
      prev_door = 1'b0;
      for (int c = 0; c < budget && !finished; c++) begin
         if (c == inject_at) begin
            passenger_1 = 6'b000111;
            passenger_2 = 6'b010110;
            down_passenger = 7'b0000011;
            load = 1'b1;
         end else if (load) begin
            clearInputs();
         end
         if (busy) busy_cycles++;
         if (door_open && !prev_door) stops.push_back(int'(floor));
         prev_door = door_open;
         ob_seen |= onboard;
         if (!busy) begin
            finished = 1'b1;
            end_done = done;
         end else begin
            @(negedge clk);
         end
      end
      clearInputs();
      checkOutput("idle_reached", {31'd0, finished}, 32'd1);
   endtask

   task automatic checkSingleTrip(input string tag);
      checkOutput({tag, "_busy_cycles"}, busy_cycles, 18);
      checkOutput({tag, "_nstops"}, stops.size(), 2);
      for (int i = 0; i < 2; i++)
         if (i < stops.size())
            checkOutput($sformatf("%s_stop%0d", tag, i), stops[i], exp_t2[i]);
      checkOutput({tag, "_ob0_seen"}, {31'd0, ob_seen[0]}, 32'd1);
      checkOutput({tag, "_onboard_end"}, {25'd0, onboard}, 32'd0);
      checkOutput({tag, "_served"}, {25'd0, served}, 32'b0000001);
      checkOutput({tag, "_floor"}, {29'd0, floor}, 32'd3);
      checkOutput({tag, "_dir"}, {31'd0, dir_up}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, end_done}, 32'd1);
      @(negedge clk);
      checkOutput({tag, "_done_drop"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      clearInputs();
      doReset();
      checkOutput("rst_floor", {29'd0, floor}, 32'd0);
      checkOutput("rst_dir", {31'd0, dir_up}, 32'd1);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_moving", {31'd0, moving}, 32'd0);
      checkOutput("rst_door", {31'd0, door_open}, 32'd0);
      checkOutput("rst_onboard", {25'd0, onboard}, 32'd0);
      checkOutput("rst_served", {25'd0, served}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);

      // T3: empty request set
      applyStimulus('0, '0, '0, '0, '0, '0, '0, 7'b0, 7'b0);
      checkOutput("t3_busy", {31'd0, busy}, 32'd0);
      checkOutput("t3_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      checkOutput("t3_done_drop", {31'd0, done}, 32'd0);

      // T4: both direction bits set makes the slot invalid
      doReset();
      applyStimulus(6'b011000, '0, '0, '0, '0, '0, '0, 7'b0000001, 7'b0000001);
      checkOutput("t4_busy", {31'd0, busy}, 32'd0);
      checkOutput("t4_done", {31'd0, done}, 32'd1);
      checkOutput("t4_served", {25'd0, served}, 32'd0);
      @(negedge clk);
      checkOutput("t4_done_drop", {31'd0, done}, 32'd0);

      // T2: one passenger 0 -> 3
      doReset();
      applyStimulus(6'b011000, '0, '0, '0, '0, '0, '0, 7'b0000001, 7'b0000000);
      runToIdle(200, -1);
      checkSingleTrip("t2");

      // T5: same trip with a second load during MOVE
      doReset();
      applyStimulus(6'b011000, '0, '0, '0, '0, '0, '0, 7'b0000001, 7'b0000000);
      runToIdle(200, 5);
      checkSingleTrip("t5");

      // T1: full updown request set
      doReset();
      applyStimulus(6'b000011, 6'b110001, 6'b000101, 6'b000010, 6'b000100, 6'b111000, 6'b000000,
                    7'b0100010, 7'b0011101);
      runToIdle(500, -1);
      checkOutput("t1_nstops", stops.size(), 9);
      for (int i = 0; i < 9; i++)
         if (i < stops.size())
            checkOutput($sformatf("t1_stop%0d", i), stops[i], exp_t1[i]);
      checkOutput("t1_served", {25'd0, served}, 32'b0111111);
      checkOutput("t1_p7_never", {31'd0, ob_seen[6]}, 32'd0);
      checkOutput("t1_floor", {29'd0, floor}, 32'd0);
      checkOutput("t1_dir", {31'd0, dir_up}, 32'd1);
      checkOutput("t1_done", {31'd0, end_done}, 32'd1);

      // T6: reset while moving through floor 4
      doReset();
      applyStimulus(6'b000011, 6'b110001, 6'b000101, 6'b000010, 6'b000100, 6'b111000, 6'b000000,
                    7'b0100010, 7'b0011101);
      hit = 1'b0;
      for (int c = 0; c < 300 && !hit; c++) begin
         if (floor == 3'd4 && moving) hit = 1'b1;
         else @(negedge clk);
      end
      checkOutput("t6_reach4", {31'd0, hit}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t6_busy", {31'd0, busy}, 32'd0);
      checkOutput("t6_floor", {29'd0, floor}, 32'd0);
      checkOutput("t6_dir", {31'd0, dir_up}, 32'd1);
      checkOutput("t6_onboard", {25'd0, onboard}, 32'd0);
      checkOutput("t6_served", {25'd0, served}, 32'd0);
      checkOutput("t6_door", {31'd0, door_open}, 32'd0);
      checkOutput("t6_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t6_done_after", {31'd0, done}, 32'd0);
      checkOutput("t6_busy_after", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
